// File: rtl/adc_pkg.sv
// Shared types and default sizing for the dual-slope ADC datapath.
package adc_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  localparam int NDIG_DEF = 3;
  localparam int VW_DEF   = 10;
  localparam int AW_DEF   = 20;

endpackage

// File: rtl/contador_bcd.sv
// One BCD decade. Counts when enabled and the lower decades are all nines
// (carry_in); carry_out ripples the all-nines condition upward.
module contador_bcd
  import adc_pkg::*;
(
  input  logic       ck,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       carry_in,
  output logic       carry_out,
  output logic [3:0] q
);

  bcd_t digit;

  assign carry_out = carry_in && (digit == BCD_MAX);
  assign q         = digit;

  // Decade register: clear wins over counting, 9 rolls over to 0.
  always_ff @(posedge ck) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (en && carry_in) begin
      digit <= (digit == BCD_MAX) ? '0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/datapath_dupla_rampa.sv
// Dual-slope ADC datapath: digital integrator model, NDIG-decade BCD counter,
// and the result latch feeding the display.
module datapath_dupla_rampa
  import adc_pkg::*;
#(
  parameter int NDIG = NDIG_DEF,
  parameter int VW   = VW_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              enb_0,
  input  logic              rst_s,
  input  logic              ch_vm,
  input  logic              ch_ref,
  input  logic              ch_zr,
  input  logic              ld,
  input  logic [VW-1:0]     vm,
  input  logic [VW-1:0]     vref,
  output logic              enb_3,
  output logic              Vint_z,
  output logic [4*NDIG-1:0] result,
  output logic              valid,
  output logic              ovf
);

  logic [AW-1:0]     acc;
  logic [AW-1:0]     acc_next;
  logic [4*NDIG-1:0] count;
  logic [NDIG:0]     carry;
  logic              wrap;
  logic              ld_p1;

  // Run-up accumulation saturates instead of wrapping.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                            input logic [VW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {{(AW-VW+1){1'b0}}, b};
    return s[AW] ? {AW{1'b1}} : s[AW-1:0];
  endfunction

  // Run-down de-integration stops at zero rather than underflowing.
  function automatic logic [AW-1:0] clamp_sub(input logic [AW-1:0] a,
                                              input logic [VW-1:0] b);
    logic [AW-1:0] bx;
    bx = {{(AW-VW){1'b0}}, b};
    return (a < bx) ? '0 : a - bx;
  endfunction

  // BCD chain: digit i advances only when all lower digits are nine.
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    contador_bcd u_dig (
      .ck        (ck),
      .rst       (rst),
      .en        (enb_0),
      .clr       (rst_s),
      .carry_in  (carry[i]),
      .carry_out (carry[i+1]),
      .q         (count[4*i +: 4])
    );
  end

  // A clear in the same cycle suppresses the wrap event.
  assign wrap = enb_0 && carry[NDIG] && !rst_s;

  // Integrator next value; ch_ref beats ch_vm when both are asserted.
  always_comb begin
    acc_next = acc;
    if (rst_s || ch_zr) begin
      acc_next = '0;
    end else if (ch_ref) begin
      acc_next = clamp_sub(acc, vref);
    end else if (ch_vm) begin
      acc_next = sat_add(acc, vm);
    end
  end

  // Integrator state and registered zero-crossing flag.
  always_ff @(posedge ck) begin
    if (rst) begin
      acc    <= '0;
      Vint_z <= 1'b0;
    end else begin
      acc    <= acc_next;
      Vint_z <= ch_ref && (acc_next == '0);
    end
  end

  // Wrap pulse and sticky run-down overflow.
  always_ff @(posedge ck) begin
    if (rst) begin
      enb_3 <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      enb_3 <= wrap;
      if (rst_s) begin
        ovf <= 1'b0;
      end else if (wrap && ch_ref) begin
        ovf <= 1'b1;
      end
    end
  end

  // Result latch on the rising edge of ld; captures the pre-increment count.
  always_ff @(posedge ck) begin
    if (rst) begin
      ld_p1  <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      ld_p1 <= ld;
      valid <= ld && !ld_p1;
      if (ld && !ld_p1) begin
        result <= count;
      end
    end
  end

endmodule

// File: tb/tb_datapath_dupla_rampa.sv
// Directed, table-driven bench for the dual-slope ADC datapath.
module tb_datapath_dupla_rampa;

  logic        ck = 1'b0;
  logic        rst, enb_0, rst_s, ch_vm, ch_ref, ch_zr, ld;
  logic [9:0]  vm, vref;
  logic        enb_3, Vint_z, valid, ovf;
  logic [11:0] result;

  int n_chk  = 0;
  int n_fail = 0;

  datapath_dupla_rampa #(.NDIG(3), .VW(10), .AW(20)) dut (
    .ck     (ck),
    .rst    (rst),
    .enb_0  (enb_0),
    .rst_s  (rst_s),
    .ch_vm  (ch_vm),
    .ch_ref (ch_ref),
    .ch_zr  (ch_zr),
    .ld     (ld),
    .vm     (vm),
    .vref   (vref),
    .enb_3  (enb_3),
    .Vint_z (Vint_z),
    .result (result),
    .valid  (valid),
    .ovf    (ovf)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic        rst_s, ch_vm, ch_ref, ch_zr, enb_0, ld;
    logic [9:0]  vm, vref;
    logic [19:0] e_acc;
    logic [11:0] e_cnt, e_res;
    logic        e_vz, e_valid;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic idle();
    rst = 0; enb_0 = 0; rst_s = 0; ch_vm = 0; ch_ref = 0; ch_zr = 0; ld = 0;
  endtask

  initial begin
    int k;
    int rise_edge;
    int pulses;
    logic [19:0] prev_acc;
    logic        under;

    // row:        rst_s vm ref zr en ld  vm       vref     acc        cnt     res     vz valid
    tbl[0]  = '{0,1,0,0,1,0, 10'd100, 10'd0,   20'd100,  12'h001, 12'h000, 0, 0};
    tbl[1]  = '{0,1,0,0,0,0, 10'd50,  10'd0,   20'd150,  12'h001, 12'h000, 0, 0};
    tbl[2]  = '{0,1,1,0,1,0, 10'd100, 10'd30,  20'd120,  12'h002, 12'h000, 0, 0};
    tbl[3]  = '{0,0,1,0,0,0, 10'd0,   10'd200, 20'd0,    12'h002, 12'h000, 1, 0};
    tbl[4]  = '{0,0,1,0,0,0, 10'd0,   10'd5,   20'd0,    12'h002, 12'h000, 1, 0};
    tbl[5]  = '{0,0,0,0,0,0, 10'd0,   10'd0,   20'd0,    12'h002, 12'h000, 0, 0};
    tbl[6]  = '{0,1,0,0,1,0, 10'd1023,10'd0,   20'd1023, 12'h003, 12'h000, 0, 0};
    tbl[7]  = '{0,0,0,0,1,1, 10'd0,   10'd0,   20'd1023, 12'h004, 12'h003, 0, 1};
    tbl[8]  = '{0,0,0,0,0,1, 10'd0,   10'd0,   20'd1023, 12'h004, 12'h003, 0, 0};
    tbl[9]  = '{1,0,0,0,1,0, 10'd0,   10'd0,   20'd0,    12'h000, 12'h003, 0, 0};
    tbl[10] = '{0,1,0,1,1,0, 10'd7,   10'd0,   20'd0,    12'h001, 12'h003, 0, 0};
    tbl[11] = '{0,0,0,0,0,1, 10'd0,   10'd0,   20'd0,    12'h001, 12'h001, 0, 1};

    // Reset with every strobe active
    idle(); vm = 10'd1023; vref = 10'd1;
    rst = 1; enb_0 = 1; rst_s = 1; ch_vm = 1; ch_ref = 1; ch_zr = 1; ld = 1;
    step();
    idle();
    check("rst_enb_3",  enb_3,  0);
    check("rst_vint_z", Vint_z, 0);
    check("rst_result", result, 0);
    check("rst_valid",  valid,  0);
    check("rst_ovf",    ovf,    0);
    check("rst_acc",    dut.acc, 0);
    check("rst_count",  dut.count, 0);

    // Single-cycle vectors covering priority and clamp behaviour
    for (int i = 0; i < 12; i++) begin
      rst_s = tbl[i].rst_s; ch_vm = tbl[i].ch_vm; ch_ref = tbl[i].ch_ref;
      ch_zr = tbl[i].ch_zr; enb_0 = tbl[i].enb_0; ld = tbl[i].ld;
      vm = tbl[i].vm; vref = tbl[i].vref;
      step();
      check($sformatf("vec%0d_acc", i),    dut.acc,   tbl[i].e_acc);
      check($sformatf("vec%0d_count", i),  dut.count, tbl[i].e_cnt);
      check($sformatf("vec%0d_result", i), result,    tbl[i].e_res);
      check($sformatf("vec%0d_vint_z", i), Vint_z,    tbl[i].e_vz);
      check($sformatf("vec%0d_valid", i),  valid,     tbl[i].e_valid);
    end
    idle();
    step();

    // Counter wrap
    rst_s = 1; step(); rst_s = 0;
    enb_0 = 1;
    pulses = 0;
    for (int i = 1; i <= 999; i++) begin
      step();
      if (enb_3) pulses++;
    end
    check("wrap_count_999",   dut.count, 12'h999);
    check("wrap_early_pulse", pulses, 0);
    step();
    check("wrap_enb_3",  enb_3, 1);
    check("wrap_count0", dut.count, 0);
    check("wrap_ovf",    ovf, 0);
    enb_0 = 0;
    step();
    check("wrap_enb_3_drop", enb_3, 0);

    // Full conversion vm=500, vref=1000
    vm = 10'd500; vref = 10'd1000;
    ch_zr = 1; rst_s = 1; step(); ch_zr = 0; rst_s = 0;
    ch_vm = 1; enb_0 = 1;
    for (int i = 0; i < 1000; i++) step();
    check("conv_acc_runup", dut.acc, 20'd500000);
    check("conv_ovf_runup", ovf, 0);
    ch_vm = 0; ch_ref = 1;
    rise_edge = -1;
    for (int i = 1; i <= 600 && rise_edge < 0; i++) begin
      step();
      if (Vint_z) begin
        rise_edge = i;
        check("conv_count_at_zero", dut.count, 12'h500);
      end
    end
    check("conv_zero_edge", rise_edge, 500);
    ch_ref = 0; enb_0 = 0;
    step();
    check("conv_vint_z_drop", Vint_z, 0);
    ld = 1; step(); ld = 0;
    check("conv_result", result, 12'h500);
    check("conv_valid",  valid, 1);
    step();
    check("conv_valid_drop", valid, 0);

    // Clamp and overflow: vm=1023, vref=1
    vm = 10'd1023; vref = 10'd1;
    ch_zr = 1; rst_s = 1; step(); ch_zr = 0; rst_s = 0;
    ch_vm = 1; enb_0 = 1;
    for (int i = 0; i < 1000; i++) step();
    check("ovf_acc_runup", dut.acc, 20'd1023000);
    check("ovf_pre", ovf, 0);
    ch_vm = 0; ch_ref = 1;
    under = 0;
    prev_acc = dut.acc;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (dut.acc > prev_acc) under = 1;
      prev_acc = dut.acc;
    end
    check("ovf_no_underflow", under, 0);
    check("ovf_acc_rundown", dut.acc, 20'd1022000);
    check("ovf_enb_3", enb_3, 1);
    check("ovf_set",   ovf, 1);
    ch_ref = 0; enb_0 = 0;
    step();
    check("ovf_sticky", ovf, 1);
    rst_s = 1; step(); rst_s = 0;
    check("ovf_cleared", ovf, 0);

    // ld held high for five cycles
    pulses = 0;
    ld = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (valid) pulses++;
    end
    ld = 0;
    step();
    if (valid) pulses++;
    check("ld_held_one_valid", pulses, 1);

    // Reset in the middle of a run-down
    rst = 1; step(); rst = 0;
    vm = 10'd10; vref = 10'd25;
    ch_vm = 1; enb_0 = 1;
    for (int i = 0; i < 5; i++) step();
    check("mid_acc_runup", dut.acc, 20'd50);
    ch_vm = 0; ch_ref = 1;
    step(); step();
    check("mid_vint_z_before", Vint_z, 1);
    rst = 1; step(); rst = 0;
    check("mid_vint_z_after", Vint_z, 0);
    ch_ref = 0; enb_0 = 0;
    pulses = 0;
    for (k = 0; k < 4; k++) begin
      step();
      if (valid) pulses++;
    end
    check("mid_no_valid", pulses, 0);
    check("mid_result", result, 0);
    check("mid_acc", dut.acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
